// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32 core: sequences the shared datapath and
// decodes mux selects, write enables, immsrc and alucontrol from the current state.
module multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic [1:0] w_aluop;
  logic       w_op_legal;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  always_comb begin
    w_op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: w_op_legal = 1'b1;
      default:                                  w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Per-state datapath control; unused codes fall through to all-zero.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = 2'b00;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal = ~w_op_legal;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        alusrca = 2'b10;
        w_aluop = 2'b10;
      end
      S_EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        w_aluop = 2'b10;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca   = 2'b10;
        w_aluop   = 2'b01;
        w_pcwrite = zero;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (w_aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Enables are gated directly by resetn so none can pulse before the async clear lands.
  assign pcwrite  = resetn & w_pcwrite;
  assign memwrite = resetn & w_memwrite;
  assign irwrite  = resetn & w_irwrite;
  assign regwrite = resetn & w_regwrite;
  assign state    = r_state;

endmodule
